// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised VGA raster timing and registered RGB332 pixel output
// Revision : 1.0
// ============================================================================
module vga_timing_gen #(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   PREFETCH = 8,
  parameter int   CW       = 11
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  input  logic [7:0]    pix_in,
  output logic          pix_ce,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          active,
  output logic          line_req,
  output logic [CW-1:0] line_num,
  output logic          frame_start,
  output logic [2:0]    vgaRed,
  output logic [2:0]    vgaGreen,
  output logic [1:0]    vgaBlue,
  output logic          Hsync,
  output logic          Vsync
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   c_H_LAST   = CW'(c_H_TOTAL - 1);
  localparam logic [CW-1:0]   c_V_LAST   = CW'(c_V_TOTAL - 1);
  localparam logic [CW-1:0]   c_H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0]   c_V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0]   c_HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0]   c_HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0]   c_VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0]   c_VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0]   c_REQ_H    = CW'(c_H_TOTAL - PREFETCH);

  logic [c_DW-1:0] div_q, div_d;
  logic            pix_ce_q, pix_ce_d;
  logic [CW-1:0]   hcount_q, hcount_d;
  logic [CW-1:0]   vcount_q, vcount_d;
  logic            active_q, active_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic [7:0]      rgb_q, rgb_d;
  logic            frame_start_q, frame_start_d;
  logic            line_req_q, line_req_d;
  logic [CW-1:0]   line_num_q, line_num_d;

  logic            w_div_wrap, w_h_wrap, w_v_wrap, w_vis, w_hs_on, w_vs_on;
  logic [CW-1:0]   w_nl;

  assign w_div_wrap = (div_q == c_DIV_LAST);
  assign w_h_wrap   = (hcount_q == c_H_LAST);
  assign w_v_wrap   = (vcount_q == c_V_LAST);
  assign w_vis      = (hcount_q < c_H_ACT) && (vcount_q < c_V_ACT);
  assign w_hs_on    = (hcount_q >= c_HS_BEG) && (hcount_q < c_HS_END);
  assign w_vs_on    = (vcount_q >= c_VS_BEG) && (vcount_q < c_VS_END);

  always_comb begin
    div_d         = '0;
    pix_ce_d      = 1'b0;
    hcount_d      = '0;
    vcount_d      = '0;
    active_d      = 1'b0;
    hsync_d       = ~HS_POL;
    vsync_d       = ~VS_POL;
    rgb_d         = 8'h00;
    frame_start_d = 1'b0;
    line_req_d    = 1'b0;
    line_num_d    = line_num_q;
    w_nl          = '0;
    if (en) begin
      div_d    = w_div_wrap ? '0 : div_q + 1'b1;
      pix_ce_d = w_div_wrap;
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      active_d = active_q;
      hsync_d  = hsync_q;
      vsync_d  = vsync_q;
      rgb_d    = rgb_q;
      // Pixel outputs are sampled from the pre-increment position, one pixel behind.
      if (pix_ce_q) begin
        hcount_d = w_h_wrap ? '0 : hcount_q + 1'b1;
        if (w_h_wrap) begin
          vcount_d = w_v_wrap ? '0 : vcount_q + 1'b1;
        end
        active_d = w_vis;
        hsync_d  = w_hs_on ? HS_POL : ~HS_POL;
        vsync_d  = w_vs_on ? VS_POL : ~VS_POL;
        rgb_d    = w_vis ? pix_in : 8'h00;
      end
      // Pulses are decided from next-state values so they line up with pix_ce.
      w_nl          = (vcount_d == c_V_LAST) ? '0 : vcount_d + 1'b1;
      frame_start_d = pix_ce_d && (hcount_d == '0) && (vcount_d == '0);
      line_req_d    = pix_ce_d && (hcount_d == c_REQ_H) && (w_nl < c_V_ACT);
      if (line_req_d) begin
        line_num_d = w_nl;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q         <= '0;
      pix_ce_q      <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      active_q      <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      rgb_q         <= 8'h00;
      frame_start_q <= 1'b0;
      line_req_q    <= 1'b0;
      line_num_q    <= '0;
    end else begin
      div_q         <= div_d;
      pix_ce_q      <= pix_ce_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      line_req_q    <= line_req_d;
      line_num_q    <= line_num_d;
    end
  end

  assign pix_ce      = pix_ce_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign active      = active_q;
  assign line_req    = line_req_q;
  assign line_num    = line_num_q;
  assign frame_start = frame_start_q;
  assign vgaRed      = rgb_q[7:5];
  assign vgaGreen    = rgb_q[4:2];
  assign vgaBlue     = rgb_q[1:0];
  assign Hsync       = hsync_q;
  assign Vsync       = vsync_q;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing and pixel output stage, successor to the fixed 640x480 timing in the VGA example top level.
- Derives a pixel-clock enable from the 50 MHz system clock.
- Generates H/V counters and sync pulses with configurable porch, sync width and polarity.
- Issues line-prefetch requests to the cellular-RAM frame reader and registers the 8-bit RGB332 pixel onto vgaRed/vgaGreen/vgaBlue with blanking.

Parameters:
- CLK_DIV, 2, clk cycles per pixel (>=1); 1 gives pix_ce high every cycle while en=1
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, Hsync asserted level
- VS_POL, 0, Vsync asserted level
- PREFETCH, 8, pixels before end of line at which line_req fires (1..H_FP+H_SYNC+H_BP)
- CW, 11, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  system clock, 50 MHz
- resetn  in  1  asynchronous active-low reset
- en  in  1  run enable; low synchronously clears timing
- pix_in  in  8  RGB332 pixel for current (hcount,vcount); [7:5]=R, [4:2]=G, [1:0]=B
- pix_ce  out  1  pixel-clock enable, one clk wide
- hcount  out  CW  current horizontal position
- vcount  out  CW  current vertical line
- active  out  1  registered: displayed pixel is in visible area
- line_req  out  1  one-clk pulse requesting prefetch of line line_num
- line_num  out  CW  line to prefetch; valid while line_req=1
- frame_start  out  1  one-clk pulse at (0,0)
- vgaRed  out  3  red
- vgaGreen  out  3  green
- vgaBlue  out  2  blue
- Hsync  out  1  horizontal sync
- Vsync  out  1  vertical sync

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Region order within a line/frame is active, FP, sync, BP.
- Reset (resetn=0, async):
  - divider=0, hcount=0, vcount=0, pix_ce=0, active=0, line_req=0, line_num=0, frame_start=0.
  - Colour outputs all 0; Hsync=~HS_POL, Vsync=~VS_POL.
- Divider:
  - While en=1, div counts 0..CLK_DIV-1 and wraps.
  - pix_ce is a registered output asserted for one clk when div==CLK_DIV-1, i.e. once every CLK_DIV clks; first pix_ce is CLK_DIV clks after en rises.
- Counters advance only on pix_ce:
  - hcount wraps H_TOTAL-1 -> 0.
  - vcount increments only when hcount wraps, and wraps V_TOTAL-1 -> 0 on the same pix_ce.
- Registered outputs update on the clk edge where pix_ce=1, from pre-increment hcount/vcount, so they lag the counters by one pixel:
  - active = (hcount<H_ACTIVE) && (vcount<V_ACTIVE).
  - Hsync = HS_POL when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL. Vsync is the same rule on vcount with V_* parameters and VS_POL.
  - Colour = pix_in when the active condition holds, else 0. pix_in must be stable during the pix_ce=1 cycle.
- frame_start: one-clk pulse on the pix_ce cycle with hcount=0 and vcount=0.
- line_req:
  - One-clk pulse on the pix_ce cycle with hcount==H_TOTAL-PREFETCH, only if next line nl = (vcount==V_TOTAL-1 ? 0 : vcount+1) is < V_ACTIVE.
  - line_num=nl, registered with the pulse and held until the next line_req.
  - Fires for line 0 during the last line of vertical back porch; no requests for lines >= V_ACTIVE.
- en falling:
  - Next clk: divider, hcount, vcount cleared; pulses 0; active 0; colour 0; syncs inactive.
  - Timing restarts from (0,0) on re-enable, and frame_start fires on the first pix_ce.
- Reset mid-frame: immediate return to reset values; no partial pulses.
- All arithmetic unsigned CW-bit; widths chosen so no counter overflows before its wrap compare.

Test Plan:
- Reset held 100 ns, 20 ns clk, en=1, defaults -> pix_ce every 2nd clk; frame_start at the first pix_ce; next frame_start exactly 840000 clks (16.8 ms) later.
- Line timing -> Hsync low for exactly 96 pix_ce, first low output when hcount=657 (lag of 1); line period 1600 clks; Vsync low for 2 lines beginning on line 490.
- pix_in=8'hE3 constant -> vgaRed=7, vgaGreen=0, vgaBlue=3 for 640x480 pixels/frame; all colour 0 at hcount 640..799 and lines 480..524.
- Prefetch -> line_req fires at hcount=792 on lines 524 (line_num=0) and 0..478 (line_num=vcount+1); no line_req on lines 479..523; 480 pulses per frame.
- Params CLK_DIV=1, HS_POL=1, VS_POL=1, PREFETCH=4 -> pix_ce constant high; Hsync high 96 clks; line period 800 clks; line_req at hcount 796.
- en dropped at vcount=200 mid-line, held 10 clks, reraised -> all outputs idle within 1 clk; hcount=vcount=0; frame_start 2 clks after en rises. Async resetn pulse mid-line -> outputs at reset values without waiting for clk.
